cpu_run_controller: RTL and testbench

//  Synthesizable run sequencer for the CPU core, replacing bench-driven reset/run

---
 rtl/cpu_run_controller_if.sv | 22 ++
 rtl/cpu_run_controller.sv | 99 +++++++++
 tb/tb_cpu_run_controller.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_controller_if.sv
// Control/status bundle between the chip-level run pins and the CPU run sequencer.
interface cpu_run_controller_if #(
   parameter int unsigned CNT_W = 16
);
   logic             start;
   logic             halt_req;
   logic             cpu_reset;
   logic             cpu_run;
   logic             done;
   logic             timeout;
   logic [CNT_W-1:0] cycle_count;

   modport master (
      output start, halt_req,
      input  cpu_reset, cpu_run, done, timeout, cycle_count
   );

   modport slave (
      input  start, halt_req,
      output cpu_reset, cpu_run, done, timeout, cycle_count
   );
endinterface

// File: rtl/cpu_run_controller.sv
// Run sequencer for the CPU core: holds CPU reset after start, enables execution,
// counts RUN cycles and stops on a halt request or when the cycle budget is spent.
//
// state | meaning
// IDLE  | waiting for start; CPU held in reset
// RESET | CPU reset asserted for RST_CYCLES cycles
// RUN   | CPU executing; cycle_count advances every edge
// DONE  | run finished; CPU frozen, done/timeout/cycle_count held
module cpu_run_controller #(
   parameter int unsigned RST_CYCLES = 1,
   parameter int unsigned MAX_CYCLES = 330,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                 CLK,
   input  logic                 Reset_n,
   cpu_run_controller_if.slave  bus
);
   localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RW-1:0]    RST_LOAD = RW'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CYCLES);

   typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

   state_t           state;
   logic [RW-1:0]    rst_cnt;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] count_inc;
   logic             cpu_reset;
   logic             cpu_run;
   logic             done;
   logic             timeout;

   assign count_inc = cycle_count + CNT_W'(1);

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= IDLE;
         rst_cnt     <= '0;
         cycle_count <= '0;
         cpu_reset   <= 1'b1;
         cpu_run     <= 1'b0;
         done        <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               cpu_reset <= 1'b1;
               cpu_run   <= 1'b0;
               if (bus.start) begin
                  state       <= RESET;
                  rst_cnt     <= RST_LOAD;
                  cycle_count <= '0;
               end
            end
            RESET: begin
               if (rst_cnt == '0) begin
                  state     <= RUN;
                  cpu_reset <= 1'b0;
                  cpu_run   <= 1'b1;
               end else begin
                  rst_cnt <= rst_cnt - RW'(1);
               end
            end
            RUN: begin
               cycle_count <= count_inc;
               // halt takes priority over budget expiry on the same edge
               if (bus.halt_req) begin
                  state   <= DONE;
                  cpu_run <= 1'b0;
                  done    <= 1'b1;
                  timeout <= 1'b0;
               end else if (count_inc == MAX_C) begin
                  state   <= DONE;
                  cpu_run <= 1'b0;
                  done    <= 1'b1;
                  timeout <= 1'b1;
               end
            end
            DONE: begin
               if (bus.start) begin
                  state       <= RESET;
                  rst_cnt     <= RST_LOAD;
                  cycle_count <= '0;
                  cpu_reset   <= 1'b1;
                  done        <= 1'b0;
                  timeout     <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cpu_reset   = cpu_reset;
   assign bus.cpu_run     = cpu_run;
   assign bus.done        = done;
   assign bus.timeout     = timeout;
   assign bus.cycle_count = cycle_count;
endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: default instance plus one with RST_CYCLES=4.
module tb_cpu_run_controller;
   logic CLK = 1'b0;
   logic Reset_n = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 CLK = ~CLK;

   cpu_run_controller_if #(.CNT_W(16)) bus ();
   cpu_run_controller_if #(.CNT_W(16)) bus4 ();

   cpu_run_controller u_dut (.CLK(CLK), .Reset_n(Reset_n), .bus(bus.slave));
   cpu_run_controller #(.RST_CYCLES(4)) u_dut4 (.CLK(CLK), .Reset_n(Reset_n), .bus(bus4.slave));

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   // pack cpu_reset,cpu_run,done,timeout for compact comparisons
   function automatic logic [3:0] flags0();
      return {bus.cpu_reset, bus.cpu_run, bus.done, bus.timeout};
   endfunction
   function automatic logic [3:0] flags4();
      return {bus4.cpu_reset, bus4.cpu_run, bus4.done, bus4.timeout};
   endfunction

   task automatic start_run0();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      #12;
      chk("reset_flags", {28'd0, flags0()}, 32'b1000);
      chk("reset_count", {16'd0, bus.cycle_count}, 32'd0);
      chk("reset_flags4", {28'd0, flags4()}, 32'b1000);
      @(negedge CLK);
      Reset_n = 1'b1;
      step(2);
      chk("idle_flags", {28'd0, flags0()}, 32'b1000);
   endtask

   task automatic test_halt();
      start_run0();
      chk("halt_in_reset", {28'd0, flags0()}, 32'b1000);
      step();
      chk("halt_run_entry", {28'd0, flags0()}, 32'b0100);
      chk("halt_count0", {16'd0, bus.cycle_count}, 32'd0);
      step(49);
      chk("halt_count49", {16'd0, bus.cycle_count}, 32'd49);
      bus.halt_req = 1'b1;
      step();
      bus.halt_req = 1'b0;
      chk("halt_flags", {28'd0, flags0()}, 32'b0010);
      chk("halt_count", {16'd0, bus.cycle_count}, 32'd50);
      begin
         int bad = 0;
         for (int i = 0; i < 20; i++) begin
            step();
            if (flags0() !== 4'b0010 || bus.cycle_count !== 16'd50) bad++;
         end
         chk("halt_hold20", bad, 0);
      end
   endtask

   task automatic test_timeout();
      start_run0();
      chk("restart_flags", {28'd0, flags0()}, 32'b1000);
      chk("restart_count", {16'd0, bus.cycle_count}, 32'd0);
      step();
      step(329);
      chk("to_pre_flags", {28'd0, flags0()}, 32'b0100);
      chk("to_pre_count", {16'd0, bus.cycle_count}, 32'd329);
      step();
      chk("to_flags", {28'd0, flags0()}, 32'b0011);
      chk("to_count", {16'd0, bus.cycle_count}, 32'd330);
      step(3);
      chk("to_frozen", {16'd0, bus.cycle_count}, 32'd330);
   endtask

   task automatic test_simultaneous();
      start_run0();
      step();
      step(329);
      bus.halt_req = 1'b1;
      step();
      bus.halt_req = 1'b0;
      chk("sim_flags", {28'd0, flags0()}, 32'b0010);
      chk("sim_count", {16'd0, bus.cycle_count}, 32'd330);
   endtask

   task automatic test_async_reset();
      start_run0();
      step(11);
      chk("ar_running", {28'd0, flags0()}, 32'b0100);
      #3;
      Reset_n = 1'b0;
      #1;
      chk("ar_flags", {28'd0, flags0()}, 32'b1000);
      chk("ar_count", {16'd0, bus.cycle_count}, 32'd0);
      @(negedge CLK);
      Reset_n = 1'b1;
      step(2);
      chk("ar_idle", {28'd0, flags0()}, 32'b1000);
   endtask

   task automatic test_halt_outside_run();
      bus.halt_req = 1'b1;
      step(3);
      chk("hi_idle", {28'd0, flags0()}, 32'b1000);
      start_run0();
      chk("hi_reset", {28'd0, flags0()}, 32'b1000);
      step();
      chk("hi_run", {28'd0, flags0()}, 32'b0100);
      step();
      bus.halt_req = 1'b0;
      chk("hi_done", {28'd0, flags0()}, 32'b0010);
      chk("hi_count", {16'd0, bus.cycle_count}, 32'd1);
   endtask

   task automatic count_reset4(input string name);
      int high = 1;
      int guard = 0;
      step();
      while (bus4.cpu_run !== 1'b1 && guard < 20) begin
         if (bus4.cpu_reset === 1'b1) high++;
         step();
         guard++;
      end
      chk(name, high, 4);
   endtask

   task automatic test_rst4();
      bus4.start = 1'b1;
      step();
      chk("r4_reset", {28'd0, flags4()}, 32'b1000);
      count_reset4("r4_reset_len");
      chk("r4_run", {28'd0, flags4()}, 32'b0100);
      step(5);
      chk("r4_start_in_run", {16'd0, bus4.cycle_count}, 32'd5);
      chk("r4_run_flags", {28'd0, flags4()}, 32'b0100);
      bus4.start = 1'b0;
      bus4.halt_req = 1'b1;
      step();
      bus4.halt_req = 1'b0;
      chk("r4_done", {28'd0, flags4()}, 32'b0010);
      chk("r4_done_count", {16'd0, bus4.cycle_count}, 32'd6);
      bus4.start = 1'b1;
      step();
      bus4.start = 1'b0;
      chk("r4_restart", {28'd0, flags4()}, 32'b1000);
      chk("r4_restart_count", {16'd0, bus4.cycle_count}, 32'd0);
      count_reset4("r4_restart_len");
   endtask

   initial begin
      bus.start = 1'b0;
      bus.halt_req = 1'b0;
      bus4.start = 1'b0;
      bus4.halt_req = 1'b0;
      test_reset();
      test_halt();
      test_timeout();
      test_simultaneous();
      test_async_reset();
      test_halt_outside_run();
      test_rst4();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
